// File: rtl/layer_argmax.sv
// Argmax over NUM_CLASSES binary16 scores arriving serially on a valid/ready stream.
// The winning index and its score are held until the consumer acknowledges them.
module layer_argmax #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned IDX_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              score_valid,
  input  logic [DATA_W-1:0] score_in,
  output logic              score_ready,
  output logic              result_valid,
  output logic [IDX_W-1:0]  result_idx,
  output logic [DATA_W-1:0] result_score,
  input  logic              result_ack,
  output logic              busy
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned MAG_W = DATA_W - 1;
  localparam int unsigned MAN_W = 10;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_RESULT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               found_q, found_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [DATA_W-1:0]  best_score_q, best_score_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  // Sign-magnitude compare; zero magnitude is treated as positive so +0 == -0.
  logic [MAG_W-1:0] in_mag, best_mag;
  logic             in_nan, best_nan, in_neg, best_neg, in_gt_c, replace_c;

  always_comb begin
    in_mag   = score_in[MAG_W-1:0];
    best_mag = best_score_q[MAG_W-1:0];
    in_nan   = (&in_mag[MAG_W-1:MAN_W]) && (|in_mag[MAN_W-1:0]);
    best_nan = (&best_mag[MAG_W-1:MAN_W]) && (|best_mag[MAN_W-1:0]);
    in_neg   = score_in[DATA_W-1] && (|in_mag);
    best_neg = best_score_q[DATA_W-1] && (|best_mag);
    if (in_neg != best_neg) begin
      in_gt_c = !in_neg;
    end else if (in_neg) begin
      in_gt_c = in_mag < best_mag;
    end else begin
      in_gt_c = in_mag > best_mag;
    end
    replace_c = !found_q || (best_nan && !in_nan) || (!in_nan && !best_nan && in_gt_c);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    found_d      = found_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COLLECT;
          cnt_d   = '0;
          found_d = 1'b0;
        end
      end
      S_COLLECT: begin
        if (start) begin
          cnt_d   = '0;
          found_d = 1'b0;
        end else if (score_valid && ready_q) begin
          cnt_d   = cnt_q + CNT_W'(1);
          found_d = 1'b1;
          if (replace_c) begin
            best_idx_d   = IDX_W'(cnt_q);
            best_score_d = score_in;
          end
          if (cnt_q == LAST_CNT) begin
            state_d = S_RESULT;
          end
        end
      end
      S_RESULT: begin
        if (result_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_COLLECT);
    valid_d = (state_d == S_RESULT);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      found_q      <= 1'b0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      ready_q      <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      found_q      <= found_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      ready_q      <= ready_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  assign score_ready  = ready_q;
  assign result_valid = valid_q;
  assign result_idx   = best_idx_q;
  assign result_score = best_score_q;
  assign busy         = busy_q;

endmodule
